// File: rtl/vga_grid_engine_if.sv
// Board read port and VGA pin bundle for vga_grid_engine.
// master = timing engine, slave = board RAM / DAC side.
interface vga_grid_engine_if #(
    parameter int AW = 9,
    parameter int CW = 10
);
    logic          pix_en;
    logic          cell_rd;
    logic [AW-1:0] cell_addr;
    logic [1:0]    cell_data;
    logic          hsync;
    logic          vsync;
    logic          blank_b;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic [7:0]    r;
    logic [7:0]    g;
    logic [7:0]    b;
    logic          frame_start;

    modport master (
        output pix_en, cell_rd, cell_addr, hsync, vsync, blank_b, x, y, r, g, b, frame_start,
        input  cell_data
    );

    modport slave (
        input  pix_en, cell_rd, cell_addr, hsync, vsync, blank_b, x, y, r, g, b, frame_start,
        output cell_data
    );
endinterface

// File: rtl/vga_grid_engine.sv
// Single-clock VGA timing engine with a tile-grid renderer; pixel rate via internal clock-enable.
// Optional macro GRID_LINES_EN draws a grey grid on empty cells.
module vga_grid_engine #(
    parameter int CLK_DIV   = 2,
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int SYNC_POL  = 0,
    parameter int CW        = 10,
    parameter int CELL_W    = 32,
    parameter int CELL_H    = 32,
    parameter int GRID_COLS = 20,
    parameter int GRID_ROWS = 15,
    parameter int AW        = 9
) (
    input  logic               clk,
    input  logic               reset,
    vga_grid_engine_if.master  vga
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CW_SH   = $clog2(CELL_W);
    localparam int CH_SH   = $clog2(CELL_H);
    localparam logic SYNC_ACT = (SYNC_POL != 0);

    localparam logic [23:0] RGB_EMPTY  = 24'h000000;
    localparam logic [23:0] RGB_SNAKE  = 24'h00FF00;
    localparam logic [23:0] RGB_FOOD   = 24'hFF0000;
    localparam logic [23:0] RGB_WALL   = 24'h808080;
    localparam logic [23:0] RGB_BORDER = 24'h0000FF;

    logic [DW-1:0] div_q, div_d;
    logic          pix_en_q, pix_en_d;
    logic [CW-1:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    logic          frame_start_q, frame_start_d;
    // stage 0: address issue plus the counter-derived attributes that travel with it
    logic          cell_rd_q, cell_rd_d;
    logic [AW-1:0] cell_addr_q, cell_addr_d;
    logic          s0_vis_q, s0_vis_d, s0_hs_q, s0_hs_d, s0_vs_q, s0_vs_d;
    logic [CW-1:0] s0_x_q, s0_x_d, s0_y_q, s0_y_d;
`ifdef GRID_LINES_EN
    logic          s0_line_q, s0_line_d;
`endif
    // stage 2: pin registers
    logic          hsync_q, hsync_d, vsync_q, vsync_d, blank_b_q, blank_b_d;
    logic [CW-1:0] x_q, x_d, y_q, y_d;
    logic [23:0]   rgb_q, rgb_d;

    logic [31:0]   h32, v32, col, row;
    logic          last_div, h_last, v_last, vis, in_grid;
    logic [23:0]   rgb_c;

    always_comb begin
        h32      = 32'(hcnt_q);
        v32      = 32'(vcnt_q);
        col      = h32 >> CW_SH;
        row      = v32 >> CH_SH;
        last_div = (32'(div_q) == 32'(CLK_DIV - 1));
        h_last   = (h32 == 32'(H_TOTAL - 1));
        v_last   = (v32 == 32'(V_TOTAL - 1));
        vis      = (h32 < 32'(H_ACTIVE)) && (v32 < 32'(V_ACTIVE));
        in_grid  = vis && (h32 < 32'(GRID_COLS * CELL_W)) && (v32 < 32'(GRID_ROWS * CELL_H));

        rgb_c = RGB_EMPTY;
        if (s0_vis_q) begin
            if (!cell_rd_q) begin
                rgb_c = RGB_BORDER;
            end else begin
                case (vga.cell_data)
`ifdef GRID_LINES_EN
                    2'd0:    rgb_c = s0_line_q ? 24'h404040 : RGB_EMPTY;
`else
                    2'd0:    rgb_c = RGB_EMPTY;
`endif
                    2'd1:    rgb_c = RGB_SNAKE;
                    2'd2:    rgb_c = RGB_FOOD;
                    default: rgb_c = RGB_WALL;
                endcase
            end
        end

        div_d         = last_div ? '0 : div_q + 1'b1;
        pix_en_d      = last_div;
        frame_start_d = pix_en_q && h_last && v_last;
        hcnt_d        = hcnt_q;
        vcnt_d        = vcnt_q;
        cell_rd_d     = cell_rd_q;
        cell_addr_d   = cell_addr_q;
        s0_vis_d      = s0_vis_q;
        s0_hs_d       = s0_hs_q;
        s0_vs_d       = s0_vs_q;
        s0_x_d        = s0_x_q;
        s0_y_d        = s0_y_q;
`ifdef GRID_LINES_EN
        s0_line_d     = s0_line_q;
`endif
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        blank_b_d     = blank_b_q;
        x_d           = x_q;
        y_d           = y_q;
        rgb_d         = rgb_q;

        if (pix_en_q) begin
            hcnt_d = h_last ? '0 : hcnt_q + 1'b1;
            if (h_last) vcnt_d = v_last ? '0 : vcnt_q + 1'b1;

            cell_rd_d   = in_grid;
            cell_addr_d = in_grid ? AW'(row * 32'(GRID_COLS) + col) : '0;
            s0_vis_d    = vis;
            s0_hs_d     = (h32 >= 32'(H_ACTIVE + H_FP)) && (h32 < 32'(H_ACTIVE + H_FP + H_SYNC));
            s0_vs_d     = (v32 >= 32'(V_ACTIVE + V_FP)) && (v32 < 32'(V_ACTIVE + V_FP + V_SYNC));
            s0_x_d      = hcnt_q;
            s0_y_d      = vcnt_q;
`ifdef GRID_LINES_EN
            s0_line_d   = ((h32 & 32'(CELL_W - 1)) == 32'd0) || ((v32 & 32'(CELL_H - 1)) == 32'd0);
`endif
            // board data for the stage-0 address is valid now; colour it straight into the pins
            hsync_d     = s0_hs_q ? SYNC_ACT : ~SYNC_ACT;
            vsync_d     = s0_vs_q ? SYNC_ACT : ~SYNC_ACT;
            blank_b_d   = s0_vis_q;
            x_d         = s0_x_q;
            y_d         = s0_y_q;
            rgb_d       = rgb_c;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q         <= '0;
            pix_en_q      <= 1'b0;
            hcnt_q        <= '0;
            vcnt_q        <= '0;
            frame_start_q <= 1'b0;
            cell_rd_q     <= 1'b0;
            cell_addr_q   <= '0;
            s0_vis_q      <= 1'b0;
            s0_hs_q       <= 1'b0;
            s0_vs_q       <= 1'b0;
            s0_x_q        <= '0;
            s0_y_q        <= '0;
`ifdef GRID_LINES_EN
            s0_line_q     <= 1'b0;
`endif
            hsync_q       <= ~SYNC_ACT;
            vsync_q       <= ~SYNC_ACT;
            blank_b_q     <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            rgb_q         <= '0;
        end else begin
            div_q         <= div_d;
            pix_en_q      <= pix_en_d;
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            frame_start_q <= frame_start_d;
            cell_rd_q     <= cell_rd_d;
            cell_addr_q   <= cell_addr_d;
            s0_vis_q      <= s0_vis_d;
            s0_hs_q       <= s0_hs_d;
            s0_vs_q       <= s0_vs_d;
            s0_x_q        <= s0_x_d;
            s0_y_q        <= s0_y_d;
`ifdef GRID_LINES_EN
            s0_line_q     <= s0_line_d;
`endif
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            blank_b_q     <= blank_b_d;
            x_q           <= x_d;
            y_q           <= y_d;
            rgb_q         <= rgb_d;
        end
    end

    assign vga.pix_en      = pix_en_q;
    assign vga.cell_rd     = cell_rd_q;
    assign vga.cell_addr   = cell_addr_q;
    assign vga.hsync       = hsync_q;
    assign vga.vsync       = vsync_q;
    assign vga.blank_b     = blank_b_q;
    assign vga.x           = x_q;
    assign vga.y           = y_q;
    assign vga.r           = rgb_q[23:16];
    assign vga.g           = rgb_q[15:8];
    assign vga.b           = rgb_q[7:0];
    assign vga.frame_start = frame_start_q;
endmodule
